// File: rtl/cmp_nic.sv
// CMP node network interface: one-packet inbound and outbound buffers between the
// processor NIC port and the router port, with polarity-gated outbound send.
module cmp_nic #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [0:1]    addr_nic,
    input  logic [0:DW-1] din_nic,
    output logic [0:DW-1] dout_nic,
    input  logic          nicEn,
    input  logic          nicWrEn,
    input  logic          net_si,
    output logic          net_ri,
    input  logic [0:DW-1] net_di,
    output logic          net_so,
    input  logic          net_ro,
    output logic [0:DW-1] net_do,
    input  logic          net_polarity
);

    localparam logic [0:1] ADDR_IB     = 2'b00;
    localparam logic [0:1] ADDR_IB_STS = 2'b01;
    localparam logic [0:1] ADDR_OB     = 2'b10;
    localparam logic [0:1] ADDR_OB_STS = 2'b11;

    logic [0:DW-1] ib_q, ib_d;
    logic          ib_full_q, ib_full_d;
    logic [0:DW-1] ob_q, ob_d;
    logic          ob_full_q, ob_full_d;
    logic [0:DW-1] dout_q, dout_d;

    logic rd_en;
    logic wr_en;

    assign rd_en    = nicEn & ~nicWrEn;
    assign wr_en    = nicEn & nicWrEn;

    assign net_ri   = ~ib_full_q;
    assign net_do   = ob_q;
    assign net_so   = ob_full_q & net_ro & (ob_q[0] == net_polarity);
    assign dout_nic = dout_q;

    always_comb begin
        ib_d      = ib_q;
        ib_full_d = ib_full_q;
        ob_d      = ob_q;
        ob_full_d = ob_full_q;
        dout_d    = dout_q;

        // Capture and read-clear are mutually exclusive: capture needs empty, clear needs full.
        if (net_si && !ib_full_q) begin
            ib_d      = net_di;
            ib_full_d = 1'b1;
        end

        if (rd_en) begin
            case (addr_nic)
                ADDR_IB: begin
                    dout_d = ib_q;
                    if (ib_full_q) begin
                        ib_full_d = 1'b0;
                    end
                end
                ADDR_IB_STS: dout_d = {{(DW-1){1'b0}}, ib_full_q};
                ADDR_OB:     dout_d = '0;
                ADDR_OB_STS: dout_d = {{(DW-1){1'b0}}, ob_full_q};
                default:     dout_d = dout_q;
            endcase
        end

        // A write on the send edge sees ob_full=1 and is dropped.
        if (wr_en && (addr_nic == ADDR_OB) && !ob_full_q) begin
            ob_d      = din_nic;
            ob_full_d = 1'b1;
        end

        if (net_so) begin
            ob_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ib_q      <= '0;
            ib_full_q <= 1'b0;
            ob_q      <= '0;
            ob_full_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            ib_q      <= ib_d;
            ib_full_q <= ib_full_d;
            ob_q      <= ob_d;
            ob_full_q <= ob_full_d;
            dout_q    <= dout_d;
        end
    end

endmodule

// File: tb/tb_cmp_nic.sv
// Directed bench for cmp_nic: a vector table for single-edge behaviour plus
// hand-written sequences for pulse width, back-pressure, same-edge and reset cases.
module tb_cmp_nic;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [0:1]    addr_nic = 2'b00;
    logic [0:DW-1] din_nic = '0;
    logic [0:DW-1] dout_nic;
    logic          nicEn = 1'b0;
    logic          nicWrEn = 1'b0;
    logic          net_si = 1'b0;
    logic          net_ri;
    logic [0:DW-1] net_di = '0;
    logic          net_so;
    logic          net_ro = 1'b0;
    logic [0:DW-1] net_do;
    logic          net_polarity = 1'b0;

    int total = 0;
    int bad = 0;

    cmp_nic #(.DW(DW)) dut (
        .clk(clk), .reset(reset), .addr_nic(addr_nic), .din_nic(din_nic),
        .dout_nic(dout_nic), .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si),
        .net_ri(net_ri), .net_di(net_di), .net_so(net_so), .net_ro(net_ro),
        .net_do(net_do), .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          we;
        logic [0:1]    addr;
        logic [0:DW-1] din;
        logic          si;
        logic [0:DW-1] di;
        logic          ro;
        logic          pol;
        logic [0:DW-1] e_dout;
        logic          e_ri;
        logic          e_so;
        logic [0:DW-1] e_do;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic we, logic [0:1] addr, logic [0:DW-1] din,
                                logic si, logic [0:DW-1] di, logic ro, logic pol,
                                logic [0:DW-1] e_dout, logic e_ri, logic e_so,
                                logic [0:DW-1] e_do);
        vec_t v;
        v.en = en; v.we = we; v.addr = addr; v.din = din; v.si = si; v.di = di;
        v.ro = ro; v.pol = pol; v.e_dout = e_dout; v.e_ri = e_ri; v.e_so = e_so;
        v.e_do = e_do;
        return v;
    endfunction

    task automatic chk(input string name, input logic [0:DW-1] act, input logic [0:DW-1] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic we, input logic [0:1] addr,
                       input logic [0:DW-1] din, input logic si, input logic [0:DW-1] di);
        @(negedge clk);
        nicEn = en; nicWrEn = we; addr_nic = addr; din_nic = din;
        net_si = si; net_di = di;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        nicEn = 1'b0; nicWrEn = 1'b0; addr_nic = 2'b00; din_nic = '0;
        net_si = 1'b0; net_di = '0;
    endtask

    localparam logic [0:DW-1] PA   = 64'hA5A5_0000_0000_0001;
    localparam logic [0:DW-1] PB   = 64'h0123_4567_89AB_CDEF;
    localparam logic [0:DW-1] PC   = 64'h8000_0000_0000_0001;
    localparam logic [0:DW-1] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [0:DW-1] Z    = 64'h0;
    localparam logic [0:DW-1] ONE  = 64'h1;

    initial begin
        // en we addr din si di ro pol | dout ri so do
        vecs.push_back(mk(1,0,2'b01,Z,   0,Z, 0,0, Z,  1,0,Z));
        vecs.push_back(mk(1,0,2'b11,Z,   0,Z, 0,0, Z,  1,0,Z));
        vecs.push_back(mk(0,0,2'b00,Z,   1,PA,0,0, Z,  0,0,Z));
        vecs.push_back(mk(1,0,2'b01,Z,   0,Z, 0,0, ONE,0,0,Z));
        vecs.push_back(mk(1,0,2'b00,Z,   0,Z, 0,0, PA, 1,0,Z));
        vecs.push_back(mk(1,0,2'b01,Z,   0,Z, 0,0, Z,  1,0,Z));
        vecs.push_back(mk(1,0,2'b00,Z,   0,Z, 0,0, PA, 1,0,Z));
        vecs.push_back(mk(1,1,2'b10,PB,  0,Z, 1,1, PA, 1,0,PB));
        vecs.push_back(mk(0,0,2'b00,Z,   0,Z, 1,1, PA, 1,0,PB));
        vecs.push_back(mk(0,0,2'b00,Z,   0,Z, 1,0, PA, 1,0,PB));
        vecs.push_back(mk(1,0,2'b11,Z,   0,Z, 1,0, Z,  1,0,PB));
        vecs.push_back(mk(1,1,2'b10,PC,  0,Z, 0,0, Z,  1,0,PC));
        vecs.push_back(mk(1,1,2'b10,ONES,0,Z, 0,0, Z,  1,0,PC));
        vecs.push_back(mk(1,0,2'b11,Z,   0,Z, 0,0, ONE,1,0,PC));
        vecs.push_back(mk(0,0,2'b00,Z,   0,Z, 1,1, ONE,1,0,PC));
        vecs.push_back(mk(1,0,2'b11,Z,   0,Z, 1,1, Z,  1,0,PC));
        vecs.push_back(mk(1,0,2'b00,Z,   0,Z, 1,1, PA, 1,0,PC));
        vecs.push_back(mk(1,0,2'b10,Z,   0,Z, 1,1, Z,  1,0,PC));
        vecs.push_back(mk(1,1,2'b00,ONES,0,Z, 0,0, Z,  1,0,PC));
        vecs.push_back(mk(1,0,2'b01,Z,   0,Z, 0,0, Z,  1,0,PC));
        vecs.push_back(mk(1,0,2'b00,Z,   0,Z, 0,0, PA, 1,0,PC));

        // Reset asserted mid-cycle, held for ten cycles.
        #3 reset = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ri",   {63'b0, net_ri}, ONE);
        chk("rst_so",   {63'b0, net_so}, Z);
        chk("rst_dout", dout_nic, Z);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            nicEn = vecs[i].en; nicWrEn = vecs[i].we; addr_nic = vecs[i].addr;
            din_nic = vecs[i].din; net_si = vecs[i].si; net_di = vecs[i].di;
            net_ro = vecs[i].ro; net_polarity = vecs[i].pol;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_dout", i), dout_nic, vecs[i].e_dout);
            chk($sformatf("v%0d_ri", i), {63'b0, net_ri}, {63'b0, vecs[i].e_ri});
            chk($sformatf("v%0d_so", i), {63'b0, net_so}, {63'b0, vecs[i].e_so});
            chk($sformatf("v%0d_do", i), net_do, vecs[i].e_do);
        end

        // Polarity release: net_so is high for exactly one cycle; status read on that edge sees 1.
        net_ro = 1'b1; net_polarity = 1'b1;
        cyc(1, 1, 2'b10, PB, 0, Z);
        chk("pol_hold_so", {63'b0, net_so}, Z);
        @(negedge clk);
        idle_inputs();
        net_polarity = 1'b0;
        nicEn = 1'b1; addr_nic = 2'b11;
        #1;
        chk("pol_so_hi", {63'b0, net_so}, ONE);
        chk("pol_do",    net_do, PB);
        @(posedge clk);
        #1;
        chk("pol_so_lo",    {63'b0, net_so}, Z);
        chk("pol_sts_edge", dout_nic, ONE);
        cyc(1, 0, 2'b11, Z, 0, Z);
        chk("pol_sts_after", dout_nic, Z);

        // Back-pressure: second strobe while full is ignored.
        net_ro = 1'b0;
        cyc(0, 0, 2'b00, Z, 1, 64'h1111_2222_3333_4444);
        chk("bp_ri0", {63'b0, net_ri}, Z);
        cyc(0, 0, 2'b00, Z, 1, 64'hDEAD_BEEF_0000_0000);
        chk("bp_ri1", {63'b0, net_ri}, Z);
        cyc(1, 0, 2'b00, Z, 0, Z);
        chk("bp_data", dout_nic, 64'h1111_2222_3333_4444);
        chk("bp_ri2",  {63'b0, net_ri}, ONE);

        // Write to output buffer on the same edge as a send is dropped.
        net_ro = 1'b0; net_polarity = 1'b1;
        cyc(1, 1, 2'b10, 64'h8765_4321_0000_00FF, 0, Z);
        chk("se_so_idle", {63'b0, net_so}, Z);
        @(negedge clk);
        net_ro = 1'b1;
        nicEn = 1'b1; nicWrEn = 1'b1; addr_nic = 2'b10; din_nic = 64'h0000_1111_2222_3333;
        #1;
        chk("se_so_hi", {63'b0, net_so}, ONE);
        @(posedge clk);
        #1;
        chk("se_so_lo", {63'b0, net_so}, Z);
        chk("se_do",    net_do, 64'h8765_4321_0000_00FF);
        cyc(1, 0, 2'b11, Z, 0, Z);
        chk("se_sts", dout_nic, Z);

        // Reset in the middle of a pending send discards both buffers.
        net_ro = 1'b0; net_polarity = 1'b0;
        cyc(0, 0, 2'b00, Z, 1, 64'hCAFE_0000_0000_0000);
        cyc(1, 1, 2'b10, 64'h0000_0000_0000_0042, 0, Z);
        chk("mr_ri_full", {63'b0, net_ri}, Z);
        @(negedge clk);
        idle_inputs();
        net_ro = 1'b1;
        #1;
        chk("mr_so_pre", {63'b0, net_so}, ONE);
        #2 reset = 1'b1;
        #1;
        chk("mr_so_rst", {63'b0, net_so}, Z);
        chk("mr_ri_rst", {63'b0, net_ri}, ONE);
        chk("mr_do_rst", net_do, Z);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 0, 2'b01, Z, 0, Z);
        chk("mr_ib_sts", dout_nic, Z);
        cyc(1, 0, 2'b11, Z, 0, Z);
        chk("mr_ob_sts", dout_nic, Z);
        chk("mr_so_end", {63'b0, net_so}, Z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_nic.md
Name: cmp_nic

Overview:
- Network interface controller that sits between one CMP node's processor NIC port and its router port.
- It is the responder to the processor's nicEn/nicWrEn/addr_nic accesses.
- Holds a one-packet input channel buffer (router -> processor) and a one-packet output channel buffer (processor -> router), each with a full/empty status bit.
- Four instances live in the cmp top level, one per node, each wired to that node's node*_nic* signals.

Parameters:
- DW, 64, packet/data width; bit 0 is the MSB (big-endian [0:DW-1] ordering throughout).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr_nic  input  [0:1]  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- din_nic  input  [0:DW-1]  processor write data (packet to send).
- dout_nic  output  [0:DW-1]  registered processor read data.
- nicEn  input  1  access enable.
- nicWrEn  input  1  1 = write, 0 = read; meaningful only with nicEn=1.
- net_si  input  1  router -> NIC send strobe (incoming packet valid).
- net_ri  output  1  NIC -> router ready (input buffer empty).
- net_di  input  [0:DW-1]  incoming packet.
- net_so  output  1  NIC -> router send strobe (outgoing packet valid).
- net_ro  input  1  router ready to accept from NIC.
- net_do  output  [0:DW-1]  outgoing packet.
- net_polarity  input  1  router VC phase; a packet may leave only when its bit 0 equals net_polarity.

Behaviour:
- State: ib[0:DW-1], ib_full, ob[0:DW-1], ob_full, dout_nic register. Reset clears all to 0, so net_ri=1, net_so=0, net_do=0 and dout_nic=0. Reset applied mid-transfer discards buffered packets immediately.
- net_ri = ~ib_full (from register, no combinational path from inputs).
- Input capture: at an edge with net_si=1 and net_ri=1, ib <= net_di and ib_full <= 1. net_si while ib_full=1 is a router protocol violation; the NIC ignores it and ib is unchanged.
- Processor read (nicEn=1, nicWrEn=0): dout_nic is updated at the edge, so read data is valid one cycle after the request, matching dmem timing.
  - addr 00: dout_nic <= ib; ib_full <= 0 if it was 1. Reading while empty returns the stale ib and leaves status unchanged.
  - addr 01: dout_nic <= {DW-1 zeros, ib_full}; status sits in bit DW-1.
  - addr 10: dout_nic <= 0.
  - addr 11: dout_nic <= {DW-1 zeros, ob_full}.
- When nicEn=0, or on a write, dout_nic holds its value.
- Processor write (nicEn=1, nicWrEn=1):
  - addr 10 with ob_full=0: ob <= din_nic, ob_full <= 1.
  - addr 10 with ob_full=1: write dropped, ob unchanged.
  - Writes to 00, 01, 11 are ignored.
- Output: net_do = ob continuously. net_so = ob_full & net_ro & (ob[0] == net_polarity), combinational.
- At an edge with net_so=1, ob_full <= 0 and the packet is considered delivered. ob keeps its value, but net_so is 0 after that edge.
- Simultaneous events are evaluated with pre-edge state:
  - Write to 10 on the same edge as a send: ob_full was 1, so the write is dropped.
  - Read of 00 on the same edge as net_si: cannot collide, because net_ri=0 while full.
  - Read of 01 on the clearing edge returns the pre-edge status (1).
- Polarity mismatch holds the packet indefinitely; there is no timeout.
- No X propagation from unselected inputs: din_nic and net_di are sampled only on qualified edges.

Test Plan:
1. Reset, then check idle outputs: assert reset asynchronously mid-cycle, release after 10 cycles -> net_ri=1, net_so=0, dout_nic=0; read 01 and 11 -> both return 0.
2. Inbound packet: drive net_si=1, net_di=64'hA5A5_0000_0000_0001 for one cycle.
   - net_ri drops to 0 the next cycle.
   - Read 01 -> 64'h1.
   - Read 00 -> 64'hA5A5_0000_0000_0001 one cycle after the request.
   - net_ri=1 again and a following read of 01 -> 0.
3. Outbound with polarity gating: hold net_ro=1, net_polarity=1; write 10 with 64'h0123_4567_89AB_CDEF (bit 0 = 0).
   - net_so stays 0.
   - Flip net_polarity to 0 -> net_so=1 for exactly one cycle with net_do=64'h0123_4567_89AB_CDEF.
   - Read 11 afterwards -> 0.
4. Full output buffer drop: with net_ro=0, write 10 = 64'h8000_0000_0000_0001, then write 10 = 64'hFFFF_FFFF_FFFF_FFFF.
   - Read 11 -> 1; net_do stays 64'h8000_0000_0000_0001.
   - Raise net_ro with net_polarity=1 -> the first packet is sent and the second never appears.
5. Back-pressure and same-edge write: hold ib_full=1 and pulse net_si with new data -> ib is unchanged and a read of 00 returns the original packet. Write 10 on the same edge net_so fires -> the write is dropped and ob_full=0 after the edge.
6. Reset mid-operation: fill both buffers, assert reset -> net_so goes low immediately, net_ri goes high, both status reads return 0 after release.
